// File: rtl/prog_interval_timer_if.sv
// Control/status bundle for prog_interval_timer. The host drives it through the
// master modport, and the timer core uses the slave modport.
interface prog_interval_timer_if #(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
);
  logic               start;
  logic               cancel;
  logic               pause;
  logic               periodic;
  logic [CNT_W-1:0]   load_val;
  logic [PRESC_W-1:0] presc_div;
  logic [CNT_W-1:0]   count;
  logic               busy;
  logic               done;
  logic               expire_pulse;

  modport master (
    output start, cancel, pause, periodic, load_val, presc_div,
    input  count, busy, done, expire_pulse
  );

  modport slave (
    input  start, cancel, pause, periodic, load_val, presc_div,
    output count, busy, done, expire_pulse
  );
endinterface

// File: rtl/prog_interval_timer.sv
// Programmable interval timer with a prescaler, one-shot or auto-reload operation,
// pause/resume and cancel. It drives a registered single-cycle expiry strobe.
module prog_interval_timer #(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  prog_interval_timer_if.slave tif
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] div_q, div_d;
  logic               periodic_q, periodic_d;
  logic               expire_q, expire_d;
  logic               tick;

  // Next-state logic. Priority is cancel, then start, then pause, then tick.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    load_d     = load_q;
    presc_d    = presc_q;
    div_d      = div_q;
    periodic_d = periodic_q;
    expire_d   = 1'b0;
    tick       = (presc_q == div_q);

    if (tif.cancel) begin
      state_d = ST_IDLE;
      count_d = CNT_ZERO;
      presc_d = PRESC_ZERO;
    end else if (tif.start) begin
      load_d     = tif.load_val;
      div_d      = tif.presc_div;
      periodic_d = tif.periodic;
      presc_d    = PRESC_ZERO;
      count_d    = tif.load_val;
      if (tif.load_val == CNT_ZERO) begin
        state_d  = ST_IDLE;
        expire_d = 1'b1;
      end else begin
        state_d  = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        // The resume edge out of PAUSED evaluates a tick, so no tick is lost.
        ST_RUN, ST_PAUSED: begin
          if (tif.pause) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_RUN;
            if (tick) begin
              presc_d = PRESC_ZERO;
              if (count_q > CNT_ONE) begin
                count_d = count_q - CNT_ONE;
              end else if (count_q == CNT_ONE) begin
                expire_d = 1'b1;
                if (periodic_q) begin
                  count_d = load_q;
                end else begin
                  count_d = CNT_ZERO;
                  state_d = ST_IDLE;
                end
              end else begin
                count_d = CNT_ZERO;
                state_d = ST_IDLE;
              end
            end else begin
              presc_d = presc_q + PRESC_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
          presc_d = PRESC_ZERO;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= CNT_ZERO;
      load_q     <= CNT_ZERO;
      presc_q    <= PRESC_ZERO;
      div_q      <= PRESC_ZERO;
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      load_q     <= load_d;
      presc_q    <= presc_d;
      div_q      <= div_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
    end
  end

  assign tif.count        = count_q;
  assign tif.busy         = (state_q != ST_IDLE);
  assign tif.done         = (state_q == ST_IDLE);
  assign tif.expire_pulse = expire_q;
endmodule

// File: tb/tb_prog_interval_timer.sv
// Directed-vector bench for prog_interval_timer. Expected values are hand-derived
// from the timer's cycle timing.
module tb_prog_interval_timer;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  logic seen;

  prog_interval_timer_if #(.CNT_W(16), .PRESC_W(8)) tif ();

  prog_interval_timer #(.CNT_W(16), .PRESC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .tif (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec = n_vec + 1;
    if (obs !== exp_v) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance one edge; everything after this returns settled, 1 time unit past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int load, input int div, input logic per);
    tif.start     = 1'b1;
    tif.load_val  = 16'(load);
    tif.presc_div = 8'(div);
    tif.periodic  = per;
    cyc();
    tif.start     = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    tif.start = 1'b0; tif.cancel = 1'b0; tif.pause = 1'b0; tif.periodic = 1'b0;
    tif.load_val = 16'd0; tif.presc_div = 8'd0;
    cyc(); cyc();
    rst = 1'b0;

    // 1: reset state and quiet idle
    chk("rst_done", 32'(tif.done), 32'd1);
    chk("rst_busy", 32'(tif.busy), 32'd0);
    chk("rst_count", 32'(tif.count), 32'd0);
    chk("rst_exp", 32'(tif.expire_pulse), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      seen = seen | tif.expire_pulse;
    end
    chk("idle_no_exp", 32'(seen), 32'd0);
    chk("idle_done", 32'(tif.done), 32'd1);

    // 2: one-shot, load 5, div 0
    do_start(5, 0, 1'b0);
    chk("os_load", 32'(tif.count), 32'd5);
    chk("os_busy", 32'(tif.busy), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("os_count", 32'(tif.count), 32'(5 - k));
      chk("os_exp", 32'(tif.expire_pulse), 32'(k == 5));
      chk("os_done", 32'(tif.done), 32'(k == 5));
    end
    cyc();
    chk("os_exp_1cyc", 32'(tif.expire_pulse), 32'd0);

    // 3: periodic, load 3, div 3 -> strobe every 12 cycles, then cancel
    do_start(3, 3, 1'b1);
    for (int k = 1; k <= 36; k++) begin
      cyc();
      chk("per_count", 32'(tif.count), 32'(3 - ((k / 4) % 3)));
      chk("per_exp", 32'(tif.expire_pulse), 32'((k % 12) == 0));
    end
    tif.cancel = 1'b1;
    cyc();
    tif.cancel = 1'b0;
    chk("cancel_count", 32'(tif.count), 32'd0);
    chk("cancel_done", 32'(tif.done), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      seen = seen | tif.expire_pulse;
    end
    chk("cancel_no_exp", 32'(seen), 32'd0);

    // 4: pause held for edges 4..9 after start, count frozen at 7
    do_start(10, 0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("pz_count", 32'(tif.count), 32'(10 - k));
    end
    tif.pause = 1'b1;
    for (int k = 4; k <= 9; k++) begin
      cyc();
      chk("pz_frozen", 32'(tif.count), 32'd7);
      chk("pz_busy", 32'(tif.busy), 32'd1);
      chk("pz_exp", 32'(tif.expire_pulse), 32'd0);
    end
    tif.pause = 1'b0;
    for (int k = 10; k <= 16; k++) begin
      cyc();
      chk("pz_resume", 32'(tif.count), 32'(16 - k));
      chk("pz_exp16", 32'(tif.expire_pulse), 32'(k == 16));
    end

    // 5a: retrigger at count 2 with load 4
    do_start(8, 0, 1'b0);
    for (int k = 1; k <= 6; k++) cyc();
    chk("rt_at2", 32'(tif.count), 32'd2);
    do_start(4, 0, 1'b0);
    chk("rt_load", 32'(tif.count), 32'd4);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      chk("rt_count", 32'(tif.count), 32'(4 - j));
      chk("rt_exp", 32'(tif.expire_pulse), 32'(j == 4));
    end

    // 5b: start coincident with the expiring tick wins, no strobe
    do_start(3, 0, 1'b0);
    cyc(); cyc();
    chk("co_at1", 32'(tif.count), 32'd1);
    do_start(6, 0, 1'b0);
    chk("co_no_exp", 32'(tif.expire_pulse), 32'd0);
    chk("co_load", 32'(tif.count), 32'd6);
    for (int j = 1; j <= 6; j++) begin
      cyc();
      chk("co_exp", 32'(tif.expire_pulse), 32'(j == 6));
    end

    // cancel while paused with prescaler active
    do_start(5, 2, 1'b0);
    cyc(); cyc();
    tif.pause = 1'b1;
    cyc(); cyc();
    tif.cancel = 1'b1;
    cyc();
    tif.cancel = 1'b0;
    tif.pause = 1'b0;
    chk("cp_done", 32'(tif.done), 32'd1);
    chk("cp_count", 32'(tif.count), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      seen = seen | tif.expire_pulse;
    end
    chk("cp_no_exp", 32'(seen), 32'd0);

    // 6: reset mid-run, then zero-load start
    do_start(9, 0, 1'b0);
    cyc(); cyc(); cyc();
    chk("mr_at6", 32'(tif.count), 32'd6);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_count", 32'(tif.count), 32'd0);
    chk("mr_done", 32'(tif.done), 32'd1);
    chk("mr_exp", 32'(tif.expire_pulse), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      seen = seen | tif.expire_pulse;
    end
    chk("mr_no_exp", 32'(seen), 32'd0);
    do_start(0, 0, 1'b1);
    chk("z_exp", 32'(tif.expire_pulse), 32'd1);
    chk("z_done", 32'(tif.done), 32'd1);
    chk("z_count", 32'(tif.count), 32'd0);
    cyc();
    chk("z_exp_once", 32'(tif.expire_pulse), 32'd0);
    chk("z_idle", 32'(tif.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
